// File: rtl/cp0_unit.sv
// Coprocessor-0 register file (SR, Cause, EPC, PRId) and interrupt request generation.
// Optional Count/Compare timer is enabled with `define CP0_TIMER_EN.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h0000_0001,
  parameter logic [31:0] EPC_RESET  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  input  logic [31:0] pc_in,
  input  logic        exl_set,
  input  logic        exl_clr,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] epc_out,
  output logic        int_request
);

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic [7:0]  r_ip;
  logic [31:0] r_epc;
  logic        w_wr;
  logic        w_ip7;
  logic        w_unused;

  // The controller pairs cp0_reg_write_en with exl_set, so entry masks the write.
  assign w_wr     = we & ~exl_set;
  assign w_unused = ^pc_in[1:0];

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timer_pending;
  logic [31:0] w_count_inc;

  assign w_count_inc = r_count + 32'd1;
  assign w_ip7       = hw_int[5] | r_timer_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count         <= 32'd0;
      r_compare       <= 32'd0;
      r_timer_pending <= 1'b0;
    end else begin
      if (w_wr && addr == 5'd9) begin
        r_count <= wdata;
      end else begin
        r_count <= w_count_inc;
      end
      // A Compare write acknowledges the timer and takes priority over a new match.
      if (w_wr && addr == 5'd11) begin
        r_compare       <= wdata;
        r_timer_pending <= 1'b0;
      end else if (!(w_wr && addr == 5'd9) && w_count_inc == r_compare) begin
        r_timer_pending <= 1'b1;
      end
    end
  end
`else
  assign w_ip7 = hw_int[5];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_im  <= 8'd0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
      r_ip  <= 8'd0;
      r_epc <= EPC_RESET;
    end else begin
      r_ip[7:2] <= {w_ip7, hw_int[4:0]};
      if (exl_set) begin
        r_epc <= {pc_in[31:2], 2'b00};
        r_exl <= 1'b1;
      end else begin
        if (exl_clr) begin
          r_exl <= 1'b0;
        end
        // An SR write in the same cycle as eret overrides the EXL clear.
        if (w_wr) begin
          case (addr)
            5'd12: begin
              r_im  <= wdata[15:8];
              r_exl <= wdata[1];
              r_ie  <= wdata[0];
            end
            5'd13:   r_ip[1:0] <= wdata[9:8];
            5'd14:   r_epc     <= {wdata[31:2], 2'b00};
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      5'd12:   rdata = {16'd0, r_im, 6'd0, r_exl, r_ie};
      5'd13:   rdata = {16'd0, r_ip, 8'd0};
      5'd14:   rdata = r_epc;
      5'd15:   rdata = PRID_VALUE;
`ifdef CP0_TIMER_EN
      5'd9:    rdata = r_count;
      5'd11:   rdata = r_compare;
`endif
      default: rdata = 32'd0;
    endcase
  end

  assign epc_out     = r_epc;
  assign int_request = r_ie & ~r_exl & (|(r_ip & r_im));

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboarded bench for cp0_unit: register reads are queued as expectations when
// the address is driven and retired when rdata settles.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hw_int;
  logic [31:0] pc_in;
  logic        exl_set;
  logic        exl_clr;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] epc_out;
  logic        int_request;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] sb_exp[$];
  string       sb_tag[$];

  cp0_unit dut (
    .clk         (clk),
    .reset       (reset),
    .hw_int      (hw_int),
    .pc_in       (pc_in),
    .exl_set     (exl_set),
    .exl_clr     (exl_clr),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .epc_out     (epc_out),
    .int_request (int_request)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string tag);
    addr = a;
    sb_exp.push_back(e);
    sb_tag.push_back(tag);
    #1;
    chk(sb_tag.pop_front(), rdata, sb_exp.pop_front());
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    step();
    we    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; hw_int = 6'd0; pc_in = 32'd0; exl_set = 1'b0; exl_clr = 1'b0;
    we = 1'b0; addr = 5'd0; wdata = 32'd0;
    step(); step();
    reset = 1'b0;

    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    rd(5'd15, 32'h1, "rst_prid");
    rd(5'd3,  32'h0, "unmapped");
    chk("rst_int", int_request, 1'b0);

    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, 32'h0000_0401, "sr_wr");
    hw_int = 6'b000001;
    #1 chk("int_before_edge", int_request, 1'b0);
    step();
    chk("int_rise", int_request, 1'b1);
    rd(5'd13, 32'h0000_0400, "cause_hw");
    hw_int = 6'd0;
    step();
    chk("int_fall", int_request, 1'b0);
    hw_int = 6'b000001;
    step();
    chk("int_rise2", int_request, 1'b1);

    pc_in = 32'h0000_3047; exl_set = 1'b1; we = 1'b1; addr = 5'd12; wdata = 32'd0;
    step();
    exl_set = 1'b0; we = 1'b0;
    rd(5'd14, 32'h0000_3044, "entry_epc");
    chk("epc_out", epc_out, 32'h0000_3044);
    rd(5'd12, 32'h0000_0403, "entry_sr");
    chk("entry_int", int_request, 1'b0);

    exl_set = 1'b1; exl_clr = 1'b1; pc_in = 32'h0000_3100;
    step();
    exl_set = 1'b0; exl_clr = 1'b0;
    rd(5'd12, 32'h0000_0403, "set_clr_sr");
    exl_clr = 1'b1;
    step();
    exl_clr = 1'b0;
    rd(5'd12, 32'h0000_0401, "eret_sr");
    chk("eret_int", int_request, 1'b1);
    exl_clr = 1'b1;
    mtc0(5'd12, 32'h0000_0403);
    exl_clr = 1'b0;
    rd(5'd12, 32'h0000_0403, "mtc0_clr_sr");
    chk("mtc0_clr_int", int_request, 1'b0);

    mtc0(5'd12, 32'h0000_0301);
    chk("sw_masked_int", int_request, 1'b0);
    mtc0(5'd13, 32'h0000_FF7C);
    chk("sw_int", int_request, 1'b1);
    rd(5'd13, 32'h0000_0700, "sw_cause");
    mtc0(5'd15, 32'h0000_DEAD);
    rd(5'd15, 32'h0000_0001, "prid_ro");
    mtc0(5'd14, 32'h1234_5677);
    rd(5'd14, 32'h1234_5674, "epc_wr");
    mtc0(5'd9, 32'h0000_0077);
`ifndef CP0_TIMER_EN
    rd(5'd9, 32'h0, "count_absent");
`endif

    reset = 1'b1; exl_set = 1'b1; pc_in = 32'h0000_5000;
    step();
    reset = 1'b0; exl_set = 1'b0; hw_int = 6'd0;
    rd(5'd14, 32'h0, "rst_entry_epc");
    rd(5'd12, 32'h0, "rst_entry_sr");
    chk("rst_entry_int", int_request, 1'b0);

`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    rd(5'd9, 32'd0, "count_load");
    for (int i = 0; i < 4; i++) step();
    rd(5'd9, 32'd4, "count_inc");
    step();
    rd(5'd9, 32'd5, "count_match");
    rd(5'd13, 32'h0, "ip7_not_yet");
    step();
    rd(5'd13, 32'h0000_8000, "ip7_set");
    mtc0(5'd11, 32'd100);
    step();
    rd(5'd13, 32'h0, "ip7_cleared");
    mtc0(5'd9, 32'hFFFF_FFFE);
    step();
    rd(5'd9, 32'hFFFF_FFFF, "count_max");
    step();
    rd(5'd9, 32'h0, "count_wrap");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
